// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O responder for the LEGLite I/O page 0xfff0-0xffff.
// Provides a debounced switch input port, a sticky switch-change status flag
// that clears on read, and a 7-segment output register.
module io_port_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        memwrite,
    input  logic        memread,
    output logic [15:0] rdata,
    output logic        io_sel,
    input  logic [1:0]  sw,
    output logic [6:0]  seg
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [15:0]     P_SW     = 16'hfff0;
    localparam logic [15:0]     P_STAT   = 16'hfff2;
    localparam logic [15:0]     P_SEG    = 16'hfffa;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    sw_db;
    logic [CW-1:0] deb_cnt;
    logic          chg;
    logic [6:0]    seg_reg;
    logic          hit_sw;
    logic          hit_stat;
    logic          hit_seg;
    logic          accept;
    logic          unused_bits;

    // Register hits ignore address bit 0 so byte and word addresses both hit.
    assign hit_sw   = (addr[15:1] == P_SW[15:1]);
    assign hit_stat = (addr[15:1] == P_STAT[15:1]);
    assign hit_seg  = (addr[15:1] == P_SEG[15:1]);
    assign io_sel   = (addr[15:4] == 12'hfff);

    // A pending switch change is taken once it has stayed stable for the full count.
    assign accept   = (s2 != sw_db) && (deb_cnt == CNT_MAX);

    // Upper store bits and address bit 0 carry no meaning for this block.
    assign unused_bits = ^{wdata[15:7], addr[0]};

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Shared debounce counter: any disagreement with the accepted value counts up, agreement restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_db   <= 2'b00;
            deb_cnt <= '0;
        end else if (s2 == sw_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_MAX) begin
            sw_db   <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
        end
    end

    // Sticky change flag: acceptance sets it and outranks a same-cycle clearing read of the status port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chg <= 1'b0;
        end else if (accept) begin
            chg <= 1'b1;
        end else if (memread && hit_stat) begin
            chg <= 1'b0;
        end
    end

    // Segment register captures the low seven store bits on a hit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_reg <= 7'h00;
        end else if (memwrite && hit_seg) begin
            seg_reg <= wdata[6:0];
        end
    end

    // Combinational read mux; unmapped addresses return zero.
    always_comb begin
        rdata = 16'h0000;
        if (hit_sw) begin
            rdata = {14'b0, sw_db};
        end else if (hit_stat) begin
            rdata = {15'b0, chg};
        end else if (hit_seg) begin
            rdata = {9'b0, seg_reg};
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed self-checking bench for io_port_ctrl with
// DEBOUNCE_CYCLES=16 and an active-high segment display.
module tb_io_port_ctrl;

    logic        clock;
    logic        resetN;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        memwrite;
    logic        memread;
    logic [15:0] rdata;
    logic        ioSel;
    logic [1:0]  sw;
    logic [6:0]  seg;

    int compareCount;
    int mismatchCount;
    logic [15:0] cpuVal;

    io_port_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clock   (clock),
        .reset_n (resetN),
        .addr    (addr),
        .wdata   (wdata),
        .memwrite(memwrite),
        .memread (memread),
        .rdata   (rdata),
        .io_sel  (ioSel),
        .sw      (sw),
        .seg     (seg)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stops a runaway simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] wd, input logic wr, input logic rd);
        addr     = a;
        wdata    = wd;
        memwrite = wr;
        memread  = rd;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One pass of the switch-to-display program: load the switches, store the matching glyph.
    task automatic runLoop(input int iterations);
        for (int i = 0; i < iterations; i++) begin
            applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b1);
            cpuVal = rdata;
            tick(1);
            applyStimulus(16'hfffa, cpuVal[0] ? 16'h0030 : 16'h007e, 1'b1, 1'b0);
            tick(1);
        end
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        resetN   = 1'b0;
        sw       = 2'b11;
        addr     = 16'hfff0;
        wdata    = 16'h0000;
        memwrite = 1'b0;
        memread  = 1'b0;

        // Reset state with switches already high.
        #22;
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        checkOutput("rstSw", rdata, 16'h0000);
        checkOutput("rstSeg", {9'b0, seg}, 16'h0000);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b0);
        checkOutput("rstChg", rdata, 16'h0000);
        checkOutput("ioSelHit", {15'b0, ioSel}, 16'h0001);
        applyStimulus(16'hffef, 16'h0000, 1'b0, 1'b0);
        checkOutput("ioSelMiss", {15'b0, ioSel}, 16'h0000);

        // Release and watch the switch value arrive on the 18th edge.
        @(posedge clock);
        #1;
        resetN = 1'b1;
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        tick(17);
        checkOutput("swBefore", rdata, 16'h0000);
        tick(1);
        checkOutput("swAccept", rdata, 16'h0003);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b0);
        checkOutput("chgSet", rdata, 16'h0001);

        // Bring switches back to zero and clear the status flag.
        sw = 2'b00;
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        tick(18);
        checkOutput("swBackZero", rdata, 16'h0000);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b1);
        tick(1);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b0);
        checkOutput("chgCleared", rdata, 16'h0000);

        // A 10-cycle glitch must be rejected.
        sw = 2'b01;
        tick(10);
        sw = 2'b00;
        tick(25);
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        checkOutput("glitchSw", rdata, 16'h0000);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b0);
        checkOutput("glitchChg", rdata, 16'h0000);

        // A pulse held for 17 cycles is accepted on edge 18.
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        sw = 2'b01;
        tick(17);
        checkOutput("pulseBefore", rdata, 16'h0000);
        sw = 2'b00;
        tick(1);
        checkOutput("pulseAccept", rdata, 16'h0001);
        sw = 2'b01;
        tick(5);

        // Segment store, readback, and ignored stores.
        applyStimulus(16'hfffa, 16'hff30, 1'b1, 1'b0);
        checkOutput("segPreWrite", {9'b0, seg}, 16'h0000);
        tick(1);
        applyStimulus(16'hfffa, 16'h0000, 1'b0, 1'b0);
        checkOutput("segWrite", {9'b0, seg}, 16'h0030);
        checkOutput("segRead", rdata, 16'h0030);
        applyStimulus(16'hfffb, 16'h0000, 1'b0, 1'b0);
        checkOutput("segOddAddr", rdata, 16'h0030);
        applyStimulus(16'hfff0, 16'hffff, 1'b1, 1'b0);
        tick(1);
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        checkOutput("swNoWrite", rdata, 16'h0001);
        applyStimulus(16'hfff4, 16'h007f, 1'b1, 1'b0);
        tick(1);
        applyStimulus(16'hfff4, 16'h0000, 1'b0, 1'b0);
        checkOutput("unusedRead", rdata, 16'h0000);
        checkOutput("segKept", {9'b0, seg}, 16'h0030);

        // Status read returns 1, the following read 0.
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b1);
        checkOutput("stat1", rdata, 16'h0001);
        tick(1);
        checkOutput("stat0", rdata, 16'h0000);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b0);

        // Acceptance coinciding with a clearing read leaves the flag set.
        sw = 2'b00;
        tick(17);
        applyStimulus(16'hfff2, 16'h0000, 1'b0, 1'b1);
        checkOutput("statPreEdge", rdata, 16'h0000);
        tick(1);
        checkOutput("statSetWins", rdata, 16'h0001);
        tick(1);
        checkOutput("statClear2", rdata, 16'h0000);
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        checkOutput("statSwDb", rdata, 16'h0000);

        // Switch-to-display program loop.
        runLoop(3);
        checkOutput("loopZero", {9'b0, seg}, 16'h007e);
        sw = 2'b01;
        runLoop(14);
        checkOutput("loopOne", {9'b0, seg}, 16'h0030);

        // Asynchronous reset in the middle of a debounce count.
        sw = 2'b00;
        tick(11);
        checkOutput("debCnt9", {12'b0, dut.deb_cnt}, 16'h0009);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("debCntRst", {12'b0, dut.deb_cnt}, 16'h0000);
        checkOutput("segBlankAsync", {9'b0, seg}, 16'h0000);
        applyStimulus(16'hfff0, 16'h0000, 1'b0, 1'b0);
        checkOutput("swRstAsync", rdata, 16'h0000);
        tick(2);
        resetN = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
